// File: rtl/dma_chain_ctrl.sv
// Purpose: descriptor-chain sequencer that programs the tiny DMA one descriptor at a time and polls its status.
// Latency: own register reads return 1 cycle after io_radr; minimum 7 cycles per valid descriptor.
// Backpressure: none; CPU writes to DMA registers during a chain write burst are dropped and flagged as collide.
// Optional macro DMA_CHAIN_IRQ_EN adds the level interrupt output chain_irq.
module dma_chain_ctrl #(
    parameter int          NDESC      = 4,
    parameter logic [13:0] CHAIN_BASE = 14'h3FC0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rst_pipe,
    input  logic        io_we,
    input  logic [13:0] io_wadr,
    input  logic [15:0] io_wdata,
    input  logic [13:0] io_radr,
    input  logic [15:0] io_rdata_in,
    output logic [15:0] io_rdata,
    output logic        dma_io_we,
    output logic [13:0] dma_io_wadr,
    output logic [15:0] dma_io_wdata,
    output logic [13:0] dma_io_radr,
    input  logic [15:0] dma_io_rdata
`ifdef DMA_CHAIN_IRQ_EN
    ,
    output logic        chain_irq
`endif
);

    localparam logic [13:0] CTRL_ADR = CHAIN_BASE + 14'h20;
    localparam logic [13:0] DESC_END = CHAIN_BASE + 14'(4 * NDESC);
    localparam logic [13:0] DMA_ST   = 14'h3FF0;
    localparam logic [13:0] DMA_IO   = 14'h3FF1;
    localparam logic [13:0] DMA_ME   = 14'h3FF2;
    localparam logic [13:0] DMA_CN   = 14'h3FF3;
    localparam logic [2:0]  LMAX     = 3'(NDESC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_IO, S_W_ME, S_W_CN, S_W_ST, S_POLL_A, S_POLL_C, S_NEXT, S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [2:0]  last;
    logic        busy;
    logic        abort_pend;
    logic        done;
    logic        err;
    logic        collide;
    logic        out_en;

    logic [15:0] d_io  [NDESC];
    logic [15:0] d_me  [NDESC];
    logic [12:0] d_cn  [NDESC];
    logic [1:0]  d_dir [NDESC];

    logic        own_hit_q;
    logic [15:0] own_val_q;

    // status bits of the DMA are the only part of its read data this block looks at
    logic [13:0] unused_rdata;
    assign unused_rdata = dma_io_rdata[15:2];

    logic [4:0]  w_off;
    logic [4:0]  r_off;
    logic        desc_wr;
    logic        ctrl_we;
    logic        cpu_dma_we;
    logic        w_state;
    logic [2:0]  lreq;
    logic [2:0]  lclamp;
    logic        start_req;
    logic        finish;
    logic        done_entry;
    logic        launch;
    logic [2:0]  nxt_idx;
    logic [1:0]  nxt_dir;
    logic        nxt_ok;
    logic        err_set;
    logic [15:0] cur_io;
    logic [15:0] cur_me;
    logic [12:0] cur_cn;
    logic [1:0]  cur_dir;
    logic        own_hit;
    logic [15:0] own_val;
    logic [15:0] status;

    assign w_off      = 5'(io_wadr - CHAIN_BASE);
    assign r_off      = 5'(io_radr - CHAIN_BASE);
    assign desc_wr    = io_we && !busy && (io_wadr >= CHAIN_BASE) && (io_wadr < DESC_END);
    assign ctrl_we    = io_we && (io_wadr == CTRL_ADR);
    assign cpu_dma_we = io_we && (io_wadr >= DMA_ST) && (io_wadr <= DMA_CN);
    assign w_state    = (state == S_W_IO) || (state == S_W_ME) || (state == S_W_CN) || (state == S_W_ST);
    assign lreq       = io_wdata[6:4];
    assign lclamp     = (lreq > LMAX) ? LMAX : lreq;
    assign start_req  = ctrl_we && io_wdata[0] && !busy;
    assign finish     = (idx == last) || abort_pend;
    assign done_entry = (state == S_NEXT) && finish;
    assign launch     = ((state == S_IDLE) && start_req) || ((state == S_NEXT) && !finish);
    assign nxt_idx    = (state == S_IDLE) ? 3'd0 : idx + 3'd1;
    assign nxt_ok     = (nxt_dir == 2'd1) || (nxt_dir == 2'd2);
    assign err_set    = launch && !nxt_ok;
    assign status     = {8'd0, idx, collide, err, done, abort_pend, busy};

    // descriptor selection: current descriptor for the write burst, next one for the direction check
    always_comb begin
        cur_io  = '0;
        cur_me  = '0;
        cur_cn  = '0;
        cur_dir = '0;
        nxt_dir = '0;
        for (int i = 0; i < NDESC; i++) begin
            if (idx == 3'(i)) begin
                cur_io  = d_io[i];
                cur_me  = d_me[i];
                cur_cn  = d_cn[i];
                cur_dir = d_dir[i];
            end
            if (nxt_idx == 3'(i)) nxt_dir = d_dir[i];
        end
    end

    // own register read decode: STATUS and descriptor words
    always_comb begin
        own_hit = 1'b0;
        own_val = '0;
        if (io_radr == CTRL_ADR) begin
            own_hit = 1'b1;
            own_val = status;
        end else if ((io_radr >= CHAIN_BASE) && (io_radr < DESC_END)) begin
            own_hit = 1'b1;
            for (int i = 0; i < NDESC; i++) begin
                if (r_off[4:2] == 3'(i)) begin
                    case (r_off[1:0])
                        2'd0:    own_val = d_io[i];
                        2'd1:    own_val = d_me[i];
                        2'd2:    own_val = {3'd0, d_cn[i]};
                        default: own_val = {14'd0, d_dir[i]};
                    endcase
                end
            end
        end
    end

    // descriptor storage survives a pipeline reset; only the hard reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDESC; i++) begin
                d_io[i]  <= '0;
                d_me[i]  <= '0;
                d_cn[i]  <= '0;
                d_dir[i] <= '0;
            end
        end else if (desc_wr) begin
            for (int i = 0; i < NDESC; i++) begin
                if (w_off[4:2] == 3'(i)) begin
                    case (w_off[1:0])
                        2'd0:    d_io[i]  <= io_wdata;
                        2'd1:    d_me[i]  <= io_wdata;
                        2'd2:    d_cn[i]  <= io_wdata[12:0];
                        default: d_dir[i] <= io_wdata[1:0];
                    endcase
                end
            end
        end
    end

    // registered own-read path and the output enable that holds the DMA port at zero through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_hit_q <= 1'b0;
            own_val_q <= '0;
            out_en    <= 1'b0;
        end else begin
            own_hit_q <= own_hit && !rst_pipe;
            own_val_q <= rst_pipe ? 16'h0 : own_val;
            out_en    <= !rst_pipe;
        end
    end

    // chain sequencer: control/status flags and descriptor walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            last       <= '0;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            collide    <= 1'b0;
        end else if (rst_pipe) begin
            state      <= S_IDLE;
            idx        <= '0;
            last       <= '0;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            collide    <= 1'b0;
        end else begin
            if (ctrl_we && io_wdata[2]) begin
                done    <= 1'b0;
                err     <= 1'b0;
                collide <= 1'b0;
            end
            if (ctrl_we && io_wdata[1] && busy) abort_pend <= 1'b1;
            if (cpu_dma_we && w_state) collide <= 1'b1;
            if (err_set) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        busy <= 1'b1;
                        idx  <= '0;
                        last <= lclamp;
                    end
                end
                S_W_IO:   state <= S_W_ME;
                S_W_ME:   state <= S_W_CN;
                S_W_CN:   state <= S_W_ST;
                S_W_ST:   state <= S_POLL_A;
                S_POLL_A: state <= S_POLL_C;
                S_POLL_C: state <= (dma_io_rdata[1:0] != 2'd0) ? S_POLL_A : S_NEXT;
                S_NEXT: begin
                    if (done_entry) state <= S_DONE;
                    else            idx   <= nxt_idx;
                end
                S_DONE: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // a descriptor with an invalid direction goes straight to NEXT without touching the DMA
            if (launch) state <= nxt_ok ? S_W_IO : S_NEXT;
        end
    end

    // DMA port: chain owns the write side in W_* states and the read address in POLL_A
    always_comb begin
        dma_io_we    = out_en && io_we;
        dma_io_wadr  = out_en ? io_wadr : 14'h0;
        dma_io_wdata = out_en ? io_wdata : 16'h0;
        dma_io_radr  = out_en ? io_radr : 14'h0;
        case (state)
            S_W_IO: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = DMA_IO;
                dma_io_wdata = cur_io;
            end
            S_W_ME: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = DMA_ME;
                dma_io_wdata = cur_me;
            end
            S_W_CN: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = DMA_CN;
                dma_io_wdata = {3'd0, cur_cn};
            end
            S_W_ST: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = DMA_ST;
                dma_io_wdata = {14'd0, cur_dir};
            end
            S_POLL_A: dma_io_radr = DMA_ST;
            default: ;
        endcase
    end

    assign io_rdata = own_hit_q ? own_val_q : io_rdata_in;

`ifdef DMA_CHAIN_IRQ_EN
    logic irq;

    // level interrupt: raised on chain completion or a bad descriptor, dropped by the flag-clear bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (rst_pipe) begin
            irq <= 1'b0;
        end else if (err_set || done_entry) begin
            irq <= 1'b1;
        end else if (ctrl_we && io_wdata[2]) begin
            irq <= 1'b0;
        end
    end

    assign chain_irq = irq;
`endif

endmodule
